// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} fsm_e;

  localparam int STG_PC     = 0;
  localparam int STG_IF     = 1;
  localparam int STG_ID     = 2;
  localparam int STG_EX     = 3;
  localparam int STG_MEM    = 4;
  localparam int STG_WB     = 5;
  localparam int NSTAGE_DEF = 6;

endpackage

// File: rtl/stall_mask_gen.sv
// Thermometer stall mask: the highest requesting stage holds itself and everything upstream.
module stall_mask_gen #(
  parameter int N = 6
) (
  input  logic [N-1:0] req,
  output logic [N-1:0] mask
);

  for (genvar i = 0; i < N; i++) begin : g_fill
    assign mask[i] = |req[N-1:i];
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline controller: stall merge, exception/ERET flush sequencing, stall watchdog and perf counter.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int NSTAGE    = NSTAGE_DEF,
  parameter int FLUSH_LEN = 1,
  parameter int TIMEOUT   = 1024,
  parameter int AW        = 32,
  parameter int CNT_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NSTAGE-1:0] stallreq_i,
  input  logic              excp_req_i,
  input  logic              excp_eret_i,
  input  logic [AW-1:0]     epc_i,
  input  logic [AW-1:0]     excp_vec_i,
  input  logic              cnt_clr_i,
  output logic [NSTAGE-1:0] stall_o,
  output logic              flush_o,
  output logic [AW-1:0]     new_pc_o,
  output logic              timeout_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  localparam int FCW = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;

  fsm_e              state;
  logic [FCW-1:0]    flush_cnt;
  logic [AW-1:0]     tgt;
  logic [NSTAGE-1:0] mask;
  logic              take;
  logic              stall_any;

  stall_mask_gen #(.N(NSTAGE)) u_mask (
    .req  (stallreq_i),
    .mask (mask)
  );

  // Flush and redirect must act in the commit cycle itself, so they are combinational.
  assign take      = (state == RUN) && excp_req_i;
  assign flush_o   = !rst && (take || (state == FLUSH));
  assign new_pc_o  = !flush_o          ? '0  :
                     (state == FLUSH)  ? tgt :
                     (excp_eret_i ? epc_i : excp_vec_i);
  assign stall_o   = (rst || flush_o) ? '0 : mask;
  assign stall_any = |stall_o;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      flush_cnt <= '0;
      tgt       <= '0;
    end else begin
      case (state)
        RUN: if (excp_req_i) begin
          tgt <= excp_eret_i ? epc_i : excp_vec_i;
          if (FLUSH_LEN > 1) begin
            state     <= FLUSH;
            flush_cnt <= FCW'(FLUSH_LEN - 1);
          end
        end
        // Requests arriving mid-flush are dropped; the flush is already committed.
        FLUSH: begin
          if (flush_cnt == FCW'(1)) state <= RUN;
          else                      flush_cnt <= flush_cnt - 1'b1;
        end
        default: state <= RUN;
      endcase
    end
  end

  if (TIMEOUT == 0) begin : g_nowd
    assign timeout_o = 1'b0;
  end else begin : g_wd
    localparam int WDW = $clog2(TIMEOUT + 1);
    logic [WDW-1:0] wd_cnt;
    logic           to_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        wd_cnt <= '0;
        to_q   <= 1'b0;
      end else if (!stall_any || flush_o) begin
        wd_cnt <= '0;
      end else begin
        if (wd_cnt == WDW'(TIMEOUT - 1)) to_q <= 1'b1;
        if (wd_cnt != WDW'(TIMEOUT))     wd_cnt <= wd_cnt + 1'b1;
      end
    end

    assign timeout_o = to_q;
  end

  always_ff @(posedge clk) begin
    if (rst || cnt_clr_i)                 stall_cnt_o <= '0;
    else if (stall_any && !(&stall_cnt_o)) stall_cnt_o <= stall_cnt_o + 1'b1;
  end

endmodule
